// File: rtl/oled_spi_if.sv
// PmodOLED SPI lines plus the decoded command/pixel outputs of the receiver.
interface oled_spi_if;
  logic        cs;
  logic        sclk;
  logic        sdin;
  logic        d_cn;
  logic [7:0]  cmd_byte;
  logic        cmd_valid;
  logic [15:0] pixel_data;
  logic [12:0] pixel_index;
  logic        pixel_valid;
  logic        frame_done;
  logic        byte_abort;
  logic [15:0] frame_xor;

  modport master (
    output cs, sclk, sdin, d_cn,
    input  cmd_byte, cmd_valid, pixel_data, pixel_index, pixel_valid,
           frame_done, byte_abort, frame_xor
  );

  modport slave (
    input  cs, sclk, sdin, d_cn,
    output cmd_byte, cmd_valid, pixel_data, pixel_index, pixel_valid,
           frame_done, byte_abort, frame_xor
  );
endinterface

// File: rtl/oled_spi_receiver.sv
// Decodes the PmodOLED SPI stream back into command bytes and indexed RGB565 pixels.
// Optional frame checksum enabled by defining OLED_RX_FRAME_XOR_EN.
module oled_spi_receiver #(
  parameter int PIXELS = 6144
) (
  input  logic       basys_clk,
  input  logic       reset_n,
  oled_spi_if.slave  spi
);

  typedef enum logic {PH_HIGH = 1'b0, PH_LOW = 1'b1} phase_e;

  localparam logic [12:0] LAST_IDX = 13'(PIXELS - 1);

  // bit 0 = metastable stage, bit 1 = synchronised, bit 2 = delayed copy for edge detect
  logic [2:0]  cs_sync_q, cs_sync_d;
  logic [2:0]  sclk_sync_q, sclk_sync_d;
  logic [1:0]  sdin_sync_q, sdin_sync_d;
  logic [1:0]  dcn_sync_q, dcn_sync_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  held_q, held_d;
  phase_e      phase_q, phase_d;
  logic [12:0] index_q, index_d;
  logic [7:0]  cmd_byte_q, cmd_byte_d;
  logic [15:0] pixel_data_q, pixel_data_d;
  logic [12:0] pixel_index_q, pixel_index_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        pixel_valid_q, pixel_valid_d;
  logic        frame_done_q, frame_done_d;
  logic        byte_abort_q, byte_abort_d;

  logic        cs_s, sdin_s, dcn_s, sclk_rise_s, cs_rise_s;
  logic [7:0]  byte_s;

  assign cs_s        = cs_sync_q[1];
  assign sdin_s      = sdin_sync_q[1];
  assign dcn_s       = dcn_sync_q[1];
  assign sclk_rise_s = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign cs_rise_s   = cs_sync_q[1] & ~cs_sync_q[2];

  // Bit capture, byte classification, pixel assembly and abort handling
  always_comb begin
    cs_sync_d     = {cs_sync_q[1:0], spi.cs};
    sclk_sync_d   = {sclk_sync_q[1:0], spi.sclk};
    sdin_sync_d   = {sdin_sync_q[0], spi.sdin};
    dcn_sync_d    = {dcn_sync_q[0], spi.d_cn};
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    held_d        = held_q;
    phase_d       = phase_q;
    index_d       = index_q;
    cmd_byte_d    = cmd_byte_q;
    pixel_data_d  = pixel_data_q;
    pixel_index_d = pixel_index_q;
    cmd_valid_d   = 1'b0;
    pixel_valid_d = 1'b0;
    frame_done_d  = 1'b0;
    byte_abort_d  = 1'b0;
    byte_s        = {shift_q[6:0], sdin_s};

    if (sclk_rise_s && !cs_s) begin
      shift_d   = byte_s;
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        if (!dcn_s) begin
          cmd_byte_d  = byte_s;
          cmd_valid_d = 1'b1;
          index_d     = 13'd0;
          phase_d     = PH_HIGH;
        end else begin
          case (phase_q)
            PH_HIGH: begin
              held_d  = byte_s;
              phase_d = PH_LOW;
            end
            PH_LOW: begin
              pixel_data_d  = {held_q, byte_s};
              pixel_index_d = index_q;
              pixel_valid_d = 1'b1;
              phase_d       = PH_HIGH;
              if (index_q == LAST_IDX) begin
                index_d      = 13'd0;
                frame_done_d = 1'b1;
              end else begin
                index_d = index_q + 13'd1;
              end
            end
            default: phase_d = PH_HIGH;
          endcase
        end
      end else begin
        held_d = held_q;
      end
    end else if (cs_rise_s && (bit_cnt_q != 3'd0)) begin
      byte_abort_d = 1'b1;
      bit_cnt_d    = 3'd0;
      shift_d      = 8'h00;
    end else begin
      shift_d = shift_q;
    end
  end

  // State and registered outputs; cs synchroniser idles high so reset never looks like a cs rise
  always_ff @(posedge basys_clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync_q     <= 3'b111;
      sclk_sync_q   <= 3'b000;
      sdin_sync_q   <= 2'b00;
      dcn_sync_q    <= 2'b00;
      shift_q       <= 8'h00;
      bit_cnt_q     <= 3'd0;
      held_q        <= 8'h00;
      phase_q       <= PH_HIGH;
      index_q       <= 13'd0;
      cmd_byte_q    <= 8'h00;
      pixel_data_q  <= 16'h0000;
      pixel_index_q <= 13'd0;
      cmd_valid_q   <= 1'b0;
      pixel_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      byte_abort_q  <= 1'b0;
    end else begin
      cs_sync_q     <= cs_sync_d;
      sclk_sync_q   <= sclk_sync_d;
      sdin_sync_q   <= sdin_sync_d;
      dcn_sync_q    <= dcn_sync_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      held_q        <= held_d;
      phase_q       <= phase_d;
      index_q       <= index_d;
      cmd_byte_q    <= cmd_byte_d;
      pixel_data_q  <= pixel_data_d;
      pixel_index_q <= pixel_index_d;
      cmd_valid_q   <= cmd_valid_d;
      pixel_valid_q <= pixel_valid_d;
      frame_done_q  <= frame_done_d;
      byte_abort_q  <= byte_abort_d;
    end
  end

`ifdef OLED_RX_FRAME_XOR_EN
  logic [15:0] acc_q, acc_d;
  logic [15:0] frame_xor_q, frame_xor_d;

  // Frame checksum: the closing word folds into the published value while the accumulator restarts
  always_comb begin
    acc_d       = acc_q;
    frame_xor_d = frame_xor_q;
    if (cmd_valid_d) begin
      acc_d = 16'h0000;
    end else if (frame_done_d) begin
      frame_xor_d = acc_q ^ pixel_data_d;
      acc_d       = 16'h0000;
    end else if (pixel_valid_d) begin
      acc_d = acc_q ^ pixel_data_d;
    end else begin
      acc_d = acc_q;
    end
  end

  // Checksum registers
  always_ff @(posedge basys_clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q       <= 16'h0000;
      frame_xor_q <= 16'h0000;
    end else begin
      acc_q       <= acc_d;
      frame_xor_q <= frame_xor_d;
    end
  end

  assign spi.frame_xor = frame_xor_q;
`else
  assign spi.frame_xor = 16'h0000;
`endif

  assign spi.cmd_byte    = cmd_byte_q;
  assign spi.cmd_valid   = cmd_valid_q;
  assign spi.pixel_data  = pixel_data_q;
  assign spi.pixel_index = pixel_index_q;
  assign spi.pixel_valid = pixel_valid_q;
  assign spi.frame_done  = frame_done_q;
  assign spi.byte_abort  = byte_abort_q;

endmodule

// File: tb/tb_oled_spi_receiver.sv
// Scoreboard bench for oled_spi_receiver; a small frame size keeps the wrap test short.
module tb_oled_spi_receiver;

  localparam int P = 8;
`ifdef OLED_RX_FRAME_XOR_EN
  localparam bit XOR_EN = 1'b1;
`else
  localparam bit XOR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] data;
    logic [12:0] idx;
    logic        fd;
    logic [15:0] xr;
  } pix_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  oled_spi_if bus();

  oled_spi_receiver #(.PIXELS(P)) dut (
    .basys_clk(clk),
    .reset_n  (rst_n),
    .spi      (bus.slave)
  );

  logic [7:0] cmd_q[$];
  pix_t       pix_q[$];
  int checks = 0;
  int errors = 0;
  int exp_abort = 0;
  int seen_abort = 0;

  logic [15:0] m_acc = 16'h0000;
  logic [15:0] m_xor = 16'h0000;
  logic [12:0] m_idx = 13'd0;
  logic        m_pend = 1'b0;
  logic [7:0]  m_held = 8'h00;

  logic [7:0]  mon_c;
  pix_t        mon_p;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe is matched against the front of its queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.cmd_valid) begin
        chk("cmd_queue_nonempty", 32'(cmd_q.size() != 0), 32'd1);
        if (cmd_q.size() != 0) begin
          mon_c = cmd_q.pop_front();
          chk("cmd_byte", 32'(bus.cmd_byte), 32'(mon_c));
        end
      end
      if (bus.pixel_valid) begin
        chk("pix_queue_nonempty", 32'(pix_q.size() != 0), 32'd1);
        if (pix_q.size() != 0) begin
          mon_p = pix_q.pop_front();
          chk("pixel_data", 32'(bus.pixel_data), 32'(mon_p.data));
          chk("pixel_index", 32'(bus.pixel_index), 32'(mon_p.idx));
          chk("frame_done", 32'(bus.frame_done), 32'(mon_p.fd));
          chk("frame_xor", 32'(bus.frame_xor), 32'(mon_p.xr));
        end
      end
      if (bus.frame_done) chk("frame_done_with_pixel", 32'(bus.pixel_valid), 32'd1);
      if (bus.byte_abort) seen_abort++;
    end
  end

  task automatic send_bits(input logic [7:0] b, input int n, input logic dc);
    bus.cs = 1'b0;
    for (int i = 7; i > 7 - n; i--) begin
      bus.sclk = 1'b0;
      bus.sdin = b[i];
      bus.d_cn = dc;
      repeat (3) @(negedge clk);
      bus.sclk = 1'b1;
      repeat (3) @(negedge clk);
    end
    bus.sclk = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    cmd_q.push_back(b);
    m_idx  = 13'd0;
    m_pend = 1'b0;
    m_acc  = 16'h0000;
    send_bits(b, 8, 1'b0);
  endtask

  task automatic send_data(input logic [7:0] b);
    pix_t e;
    if (!m_pend) begin
      m_held = b;
      m_pend = 1'b1;
    end else begin
      e.data = {m_held, b};
      e.idx  = m_idx;
      e.fd   = (m_idx == 13'(P - 1));
      if (XOR_EN) begin
        if (e.fd) begin
          m_xor = m_acc ^ e.data;
          m_acc = 16'h0000;
        end else begin
          m_acc = m_acc ^ e.data;
        end
      end
      e.xr = m_xor;
      pix_q.push_back(e);
      m_idx  = e.fd ? 13'd0 : m_idx + 13'd1;
      m_pend = 1'b0;
    end
    send_bits(b, 8, 1'b1);
  endtask

  task automatic send_pixel(input logic [15:0] w);
    send_data(w[15:8]);
    send_data(w[7:0]);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && (cmd_q.size() != 0 || pix_q.size() != 0); i++) @(negedge clk);
    chk({tag, "_cmd_drained"}, 32'(cmd_q.size()), 32'd0);
    chk({tag, "_pix_drained"}, 32'(pix_q.size()), 32'd0);
    bus.cs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_byte"}, 32'(bus.cmd_byte), 32'd0);
    chk({tag, "_pixel_data"}, 32'(bus.pixel_data), 32'd0);
    chk({tag, "_pixel_index"}, 32'(bus.pixel_index), 32'd0);
    chk({tag, "_frame_xor"}, 32'(bus.frame_xor), 32'd0);
    chk({tag, "_strobes"}, 32'({bus.cmd_valid, bus.pixel_valid, bus.frame_done, bus.byte_abort}), 32'd0);
  endtask

  initial begin
    bus.cs = 1'b1;
    bus.sclk = 1'b0;
    bus.sdin = 1'b0;
    bus.d_cn = 1'b0;
    repeat (4) @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // reset in the middle of a byte, then a clean command
    send_bits(8'hFF, 4, 1'b0);
    rst_n = 1'b0;
    bus.cs = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("mid_reset");
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    send_cmd(8'hAF);
    drain("reset");
    chk("reset_cmd_hold", 32'(bus.cmd_byte), 32'h0000_00AF);

    // command then one pixel
    send_cmd(8'hAF);
    send_data(8'hF8);
    send_data(8'h00);
    drain("cmd_pix");

    // frame wrap, word = index
    send_cmd(8'h5C);
    for (int i = 0; i <= P; i++) send_pixel(16'(i % P));
    drain("wrap");

    // checksum frame: pixel 0 = 0x1234, rest zero
    send_cmd(8'h5C);
    send_pixel(16'h1234);
    for (int i = 1; i < P; i++) send_pixel(16'h0000);
    drain("xor");
    chk("frame_xor_final", 32'(bus.frame_xor), 32'(XOR_EN ? 16'h1234 : 16'h0000));

    // abort: partial byte while phase LOW, held byte survives
    send_cmd(8'h5C);
    send_pixel(16'h1122);
    send_data(8'h12);
    send_bits(8'hFF, 5, 1'b1);
    bus.cs = 1'b1;
    exp_abort++;
    repeat (8) @(negedge clk);
    chk("abort_count_now", 32'(seen_abort), 32'(exp_abort));
    send_data(8'h34);
    drain("abort");

    // command in the middle of a pixel discards the held byte
    send_data(8'hAB);
    send_cmd(8'h15);
    send_data(8'h07);
    send_data(8'hE0);
    drain("cmd_mid");
    chk("hold_cmd_byte", 32'(bus.cmd_byte), 32'h0000_0015);
    chk("hold_pixel_data", 32'(bus.pixel_data), 32'h0000_07E0);
    chk("hold_pixel_index", 32'(bus.pixel_index), 32'd0);
    chk("abort_count_final", 32'(seen_abort), 32'(exp_abort));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
